// File: rtl/id_stage_pipe.sv
// MIPS32 decode stage: opcode classification, 2R/1W register file with
// write-through bypass, and a single valid/ready ID/EX register with flush.
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    localparam int RA_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instruction,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [5:0]        ex_opcode,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_dest,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic              ex_illegal
);
    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic [5:0]        op;
    logic [RA_W-1:0]   rs, rt, rd;
    logic              is_r, is_i, wb_hit, accept;
    logic [DATA_W-1:0] rd_a, rd_b, imm_sext;

    logic              ex_valid_q, ex_valid_d, ill_q, ill_d, rtype_q, rtype_d;
    logic [5:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [RA_W-1:0]   dest_q, dest_d, rs_q, rs_d, rt_q, rt_d;

    assign op       = instruction[31:26];
    assign rs       = instruction[21 +: RA_W];
    assign rt       = instruction[16 +: RA_W];
    assign rd       = instruction[11 +: RA_W];
    assign is_r     = (op <= 6'd5);
    assign is_i     = (op >= 6'd8) && (op <= 6'd12);
    assign imm_sext = DATA_W'(signed'(instruction[15:0]));
    assign wb_hit   = wb_en && (wb_addr != '0);

    // Same-cycle write-back wins over the array so the bundle never sees stale data.
    assign rd_a = (rs == '0) ? '0 : (wb_hit && wb_addr == rs) ? wb_data : rf_q[rs];
    assign rd_b = (rt == '0) ? '0 : (wb_hit && wb_addr == rt) ? wb_data : rf_q[rt];

    assign instr_ready = ~ex_valid_q | ex_ready | flush;
    assign accept      = instr_valid & instr_ready;

    always_comb begin
        ex_valid_d = ex_valid_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        dest_d     = dest_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        ill_d      = ill_q;
        rtype_d    = rtype_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            op_d       = op;
            a_d        = rd_a;
            b_d        = is_r ? rd_b : '0;
            imm_d      = is_i ? imm_sext : '0;
            dest_d     = is_r ? rd : rt;
            rs_d       = rs;
            rt_d       = rt;
            ill_d      = ~is_r & ~is_i;
            rtype_d    = is_r;
        end else if (ex_valid_q && !ex_ready) begin
            // Held bundle tracks write-backs so it is current when finally consumed.
            if (wb_hit && wb_addr == rs_q)            a_d = wb_data;
            if (wb_hit && wb_addr == rt_q && rtype_q) b_d = wb_data;
        end else if (ex_valid_q) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            dest_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            ill_q      <= 1'b0;
            rtype_q    <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            dest_q     <= dest_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            ill_q      <= ill_d;
            rtype_q    <= rtype_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_hit) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_opcode  = op_q;
    assign ex_a       = a_q;
    assign ex_b       = b_q;
    assign ex_imm     = imm_q;
    assign ex_dest    = dest_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_illegal = ill_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scenario bench for id_stage_pipe: directed scenarios plus a randomized run
// compared against a cycle-level reference model of the decode stage.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0, wb_en = 1'b0, flush = 1'b0, ex_ready = 1'b1;
    logic [31:0] instruction = '0, wb_data = '0;
    logic [4:0]  wb_addr = '0;
    logic        instr_ready, ex_valid, ex_illegal;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [4:0]  ex_dest, ex_rs, ex_rt;

    int total = 0;
    int bad   = 0;

    id_stage_pipe dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_rf [32];
    logic        m_valid, m_ill, m_r;
    logic [5:0]  m_op;
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_dest, m_rs, m_rt;

    logic [118:0] act;
    assign act = {ex_valid, ex_opcode, ex_a, ex_b, ex_imm, ex_dest, ex_rs, ex_rt, ex_illegal};

    function automatic logic [118:0] expb();
        return {m_valid, m_op, m_a, m_b, m_imm, m_dest, m_rs, m_rt, m_ill};
    endfunction

    function automatic logic [31:0] mk_r(int op, int rs, int rt, int rd);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'h0};
    endfunction

    function automatic logic [31:0] mk_i(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_valid = 0; m_ill = 0; m_r = 0; m_op = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_dest = 0; m_rs = 0; m_rt = 0;
    endtask

    function automatic logic [31:0] m_read(logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_rf[r];
    endfunction

    // One clock of the stage, evaluated from the inputs present at the edge.
    task automatic model_step();
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic       isr, isi, acc;
        op  = instruction[31:26];
        rs  = instruction[25:21];
        rt  = instruction[20:16];
        rd  = instruction[15:11];
        isr = op < 6;
        isi = op >= 8 && op <= 12;
        acc = instr_valid && (!m_valid || ex_ready || flush);
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_op = op; m_rs = rs; m_rt = rt; m_r = isr;
            m_a    = m_read(rs);
            m_b    = isr ? m_read(rt) : 32'h0;
            m_imm  = isi ? {{16{instruction[15]}}, instruction[15:0]} : 32'h0;
            m_dest = isr ? rd : rt;
            m_ill  = !isr && !isi;
        end else if (m_valid && !ex_ready) begin
            if (wb_en && wb_addr != 0 && wb_addr == m_rs) m_a = wb_data;
            if (wb_en && wb_addr != 0 && wb_addr == m_rt && m_r) m_b = wb_data;
        end else if (m_valid) m_valid = 0;
        if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        instr_valid = 0; wb_en = 0; flush = 0; ex_ready = 1;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 0;
        @(negedge clk);
        #1;
        total++;
        if (act !== '0 || instr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_during bundle=%h ready=%b want 0/1", act, instr_ready);
        end
        @(negedge clk);
        reset = 1;
        tick();
        total++;
        if (act !== '0 || instr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_after bundle=%h ready=%b want 0/1", act, instr_ready);
        end
    endtask

    task automatic test_rtype();
        wb_en = 1; wb_addr = 5; wb_data = 32'h1234; tick();
        wb_addr = 6; wb_data = 32'hFFFF0001; tick();
        wb_en = 0; instr_valid = 1; instruction = mk_r(0, 5, 6, 7); tick();
        instr_valid = 0;
        total++;
        if (ex_valid !== 1 || ex_a !== 32'h1234 || ex_b !== 32'hFFFF0001 || ex_dest !== 7 || ex_imm !== 0) begin
            bad++; $display("FAIL rtype got v=%b a=%h b=%h d=%0d imm=%h want 1/1234/ffff0001/7/0",
                            ex_valid, ex_a, ex_b, ex_dest, ex_imm);
        end
        total++;
        if (act !== expb()) begin bad++; $display("FAIL rtype_model got %h want %h", act, expb()); end
    endtask

    task automatic test_itype();
        instr_valid = 1; instruction = mk_i(8, 5, 9, 16'h8000); tick();
        total++;
        if (ex_imm !== 32'hFFFF8000 || ex_b !== 0 || ex_dest !== 9 || ex_illegal !== 0 || ex_a !== 32'h1234) begin
            bad++; $display("FAIL itype got imm=%h b=%h d=%0d ill=%b a=%h want ffff8000/0/9/0/1234",
                            ex_imm, ex_b, ex_dest, ex_illegal, ex_a);
        end
        instruction = mk_i(6'h3F, 1, 2, 16'h1234); tick();
        instr_valid = 0;
        total++;
        if (ex_illegal !== 1 || ex_imm !== 0 || ex_b !== 0 || ex_dest !== 2 || ex_opcode !== 6'h3F) begin
            bad++; $display("FAIL illegal got ill=%b imm=%h b=%h d=%0d want 1/0/0/2", ex_illegal, ex_imm, ex_b, ex_dest);
        end
    endtask

    task automatic test_bypass();
        instr_valid = 1; instruction = mk_r(0, 5, 6, 3);
        wb_en = 1; wb_addr = 5; wb_data = 32'hAAAA0000; tick();
        total++;
        if (ex_a !== 32'hAAAA0000 || ex_b !== 32'hFFFF0001) begin
            bad++; $display("FAIL bypass got a=%h b=%h want aaaa0000/ffff0001", ex_a, ex_b);
        end
        wb_addr = 0; wb_data = 32'hDEAD_BEEF; instruction = mk_r(0, 0, 0, 1); tick();
        wb_en = 0; instr_valid = 0;
        total++;
        if (ex_a !== 0 || ex_b !== 0 || ex_valid !== 1) begin
            bad++; $display("FAIL reg0 got a=%h b=%h v=%b want 0/0/1", ex_a, ex_b, ex_valid);
        end
    endtask

    task automatic test_stall();
        logic [118:0] held;
        instr_valid = 1; ex_ready = 1; instruction = mk_r(1, 5, 6, 7); tick();
        held = act;
        instruction = mk_i(9, 6, 2, 16'h0007); ex_ready = 0;
        for (int c = 0; c < 3; c++) begin
            wb_en = (c == 1); wb_addr = 6; wb_data = 32'h55;
            #1;
            total++;
            if (instr_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c=%0d got %b want 0", c, instr_ready); end
            tick();
            total++;
            if (act !== expb()) begin bad++; $display("FAIL stall_model c=%0d got %h want %h", c, act, expb()); end
        end
        wb_en = 0;
        total++;
        if (ex_b !== 32'h55 || ex_a !== 32'hAAAA0000 || ex_opcode !== 1 || ex_dest !== 7 || act[118:87] !== held[118:87]) begin
            bad++; $display("FAIL stall_refresh got a=%h b=%h op=%0d d=%0d want aaaa0000/55/1/7", ex_a, ex_b, ex_opcode, ex_dest);
        end
        ex_ready = 1; tick();
        instr_valid = 0;
        total++;
        if (ex_opcode !== 9 || ex_a !== 32'h55 || ex_valid !== 1 || act !== expb()) begin
            bad++; $display("FAIL stall_release got op=%0d a=%h v=%b want 9/55/1", ex_opcode, ex_a, ex_valid);
        end
    endtask

    task automatic test_flush();
        instr_valid = 1; ex_ready = 1; instruction = mk_r(2, 10, 5, 4); tick();
        ex_ready = 0; instruction = mk_r(3, 1, 2, 3); tick();
        flush = 1; wb_en = 1; wb_addr = 10; wb_data = 32'h0BADF00D;
        #1;
        total++;
        if (instr_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got %b want 1", instr_ready); end
        tick();
        flush = 0; wb_en = 0; instr_valid = 0;
        total++;
        if (ex_valid !== 0 || ex_opcode !== 2) begin
            bad++; $display("FAIL flush got v=%b op=%0d want 0/2", ex_valid, ex_opcode);
        end
        instr_valid = 1; ex_ready = 1; instruction = mk_r(0, 10, 0, 1); tick();
        instr_valid = 0;
        total++;
        if (ex_a !== 32'h0BADF00D || ex_valid !== 1) begin
            bad++; $display("FAIL flush_wb got a=%h v=%b want 0badf00d/1", ex_a, ex_valid);
        end
    endtask

    task automatic test_async_reset();
        instr_valid = 1; ex_ready = 0; instruction = mk_r(0, 5, 6, 7); tick();
        instr_valid = 0;
        #2;
        reset = 0;
        model_reset();
        #1;
        total++;
        if (act !== '0 || instr_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset got bundle=%h ready=%b want 0/1", act, instr_ready);
        end
        @(negedge clk);
        reset = 1;
        instr_valid = 1; ex_ready = 1; instruction = mk_r(0, 5, 6, 1); tick();
        instr_valid = 0;
        total++;
        if (ex_a !== 0 || ex_b !== 0 || ex_valid !== 1) begin
            bad++; $display("FAIL async_regs got a=%h b=%h v=%b want 0/0/1", ex_a, ex_b, ex_valid);
        end
    endtask

    task automatic test_random();
        int ops [11] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12};
        int op;
        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 10)];
            instr_valid = $urandom_range(0, 3) != 0;
            instruction = {op[5:0], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            wb_en       = $urandom_range(0, 1);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            ex_ready    = $urandom_range(0, 2) != 0;
            flush       = $urandom_range(0, 9) == 0;
            #1;
            total++;
            if (instr_ready !== (!m_valid || ex_ready || flush)) begin
                bad++; $display("FAIL rand_ready n=%0d got %b want %b", n, instr_ready, !m_valid || ex_ready || flush);
            end
            tick();
            total++;
            if (act !== expb()) begin bad++; $display("FAIL rand_bundle n=%0d got %h want %h", n, act, expb()); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_bypass();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
